mpt_plb: RTL and testbench

//  Protection Lookaside Buffer: fully-associative cache of MPT leaf permissions, sitting directly

---
 rtl/mpt_plb.sv | 187 ++++++++++++++++++
 tb/tb_mpt_plb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_plb.sv
// Protection Lookaside Buffer: fully-associative cache of MPT leaf permissions ahead of the walker.
// Optional per-SDID invalidation is enabled by defining MPT_PLB_SDID_FLUSH_EN.

package mpt_plb_pkg;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned SDID_LEN = 6;
  localparam int unsigned PAGE_W   = XLEN - 12;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } access_type_e;

  typedef enum logic [2:0] {
    ALLOW_NONE = 3'b000,
    ALLOW_R    = 3'b001,
    ALLOW_W    = 3'b010,
    ALLOW_RW   = 3'b011,
    ALLOW_X    = 3'b100,
    ALLOW_RX   = 3'b101,
    ALLOW_WX   = 3'b110,
    ALLOW_RWX  = 3'b111
  } mpt_permissions_e;

  typedef struct packed {
    logic [SDID_LEN-1:0] sdid;
    logic [XLEN-1:0]     spa;
    access_type_e        access;
  } plb_lookup_req_t;

  typedef struct packed {
    logic [SDID_LEN-1:0] sdid;
    logic [XLEN-1:0]     spa;
    mpt_permissions_e    perms;
  } plb_entry_t;
endpackage

// Handshake rule for both ports: a transfer happens on a rising clock edge where valid and ready
// are both high; the response payload is held stable while resp_valid_o && !resp_ready_i.
module mpt_plb
  import mpt_plb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  plb_lookup_req_t  req_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic             resp_perm_ok_o,
  output mpt_permissions_e resp_perms_o,
  input  logic             fill_valid_i,
  input  plb_entry_t       fill_entry_i
`ifdef MPT_PLB_SDID_FLUSH_EN
  ,
  input  logic                flush_sdid_i,
  input  logic [SDID_LEN-1:0] flush_sdid_id_i
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned TAG_W = SDID_LEN + PAGE_W;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
  logic [2:0]             perms_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       ptr_q;

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lk_hit, lk_ok;
  logic [2:0]       lk_perms;
  logic             fill_match, fill_free, fill_drop, fill_go;
  logic [IDX_W-1:0] match_idx, free_idx, fill_idx;
  logic [NUM_ENTRIES-1:0] sdid_kill;

  // Page offsets never take part in matching.
  logic unused_offsets;
  assign unused_offsets = ^{req_i.spa[11:0], fill_entry_i.spa[11:0]};

  assign req_tag     = {req_i.sdid, req_i.spa[XLEN-1:12]};
  assign fill_tag    = {fill_entry_i.sdid, fill_entry_i.spa[XLEN-1:12]};
  assign req_ready_o = !resp_valid_o || resp_ready_i;

  // Tags are unique, so OR-ing the matching entries yields the single hit's permissions.
  always_comb begin
    lk_hit   = 1'b0;
    lk_perms = 3'b000;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        lk_hit   = 1'b1;
        lk_perms = lk_perms | perms_q[i];
      end
    end
    case (req_i.access)
      ACCESS_READ:  lk_ok = lk_hit & lk_perms[0];
      ACCESS_WRITE: lk_ok = lk_hit & lk_perms[1];
      ACCESS_EXEC:  lk_ok = lk_hit & lk_perms[2];
      default:      lk_ok = 1'b0;
    endcase
  end

  // Scanning downwards leaves the lowest matching / free index selected.
  always_comb begin
    fill_match = 1'b0;
    fill_free  = 1'b0;
    match_idx  = '0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == fill_tag) begin
        fill_match = 1'b1;
        match_idx  = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        fill_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    fill_idx = fill_match ? match_idx : (fill_free ? free_idx : ptr_q);
  end

`ifdef MPT_PLB_SDID_FLUSH_EN
  always_comb begin
    sdid_kill = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sdid_kill[i] = flush_sdid_i && valid_q[i] &&
                     (tag_q[i][TAG_W-1 -: SDID_LEN] == flush_sdid_id_i);
    end
    fill_drop = flush_sdid_i && (fill_entry_i.sdid == flush_sdid_id_i);
  end
`else
  assign sdid_kill = '0;
  assign fill_drop = 1'b0;
`endif

  assign fill_go = fill_valid_i && !flush_i && !fill_drop;

  always_comb begin
    valid_d = valid_q & ~sdid_kill;
    if (fill_go) valid_d[fill_idx] = 1'b1;
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && fill_go) begin
      tag_q[fill_idx]   <= fill_tag;
      perms_q[fill_idx] <= fill_entry_i.perms;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      ptr_q          <= '0;
      resp_valid_o   <= 1'b0;
      resp_hit_o     <= 1'b0;
      resp_perm_ok_o <= 1'b0;
      resp_perms_o   <= ALLOW_NONE;
    end else begin
      valid_q <= valid_d;
      if (flush_i) begin
        ptr_q <= '0;
      end else if (fill_go && !fill_match && !fill_free) begin
        ptr_q <= ptr_q + IDX_W'(1);
      end
      if (req_ready_o) begin
        resp_valid_o <= req_valid_i;
        // A flush in the accept cycle turns the response into a miss.
        if (req_valid_i && !flush_i) begin
          resp_hit_o     <= lk_hit;
          resp_perm_ok_o <= lk_ok;
          resp_perms_o   <= mpt_permissions_e'(lk_perms);
        end else begin
          resp_hit_o     <= 1'b0;
          resp_perm_ok_o <= 1'b0;
          resp_perms_o   <= ALLOW_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpt_plb.sv
// Self-checking bench for mpt_plb: directed scenarios plus randomized traffic against a
// slot-array reference model; define MPT_PLB_SDID_FLUSH_EN to exercise per-SDID flush.
module tb_mpt_plb;
  import mpt_plb_pkg::*;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  plb_lookup_req_t  req;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic             resp_perm_ok;
  mpt_permissions_e resp_perms;
  logic             fill_valid;
  plb_entry_t       fill_entry;
  logic             flush_sdid;
  logic [SDID_LEN-1:0] flush_sdid_id;

  always #5 clk = ~clk;

  mpt_plb #(.NUM_ENTRIES(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_i          (req),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_hit_o     (resp_hit),
    .resp_perm_ok_o (resp_perm_ok),
    .resp_perms_o   (resp_perms),
    .fill_valid_i   (fill_valid),
    .fill_entry_i   (fill_entry)
`ifdef MPT_PLB_SDID_FLUSH_EN
    ,
    .flush_sdid_i   (flush_sdid),
    .flush_sdid_id_i(flush_sdid_id)
`endif
  );

  // Reference model: N slots, replacement pointer, expected-response queue {hit, ok, perms}.
  logic                m_valid [N];
  logic [SDID_LEN-1:0] m_sdid  [N];
  logic [PAGE_W-1:0]   m_page  [N];
  logic [2:0]          m_perms [N];
  int                  m_ptr;
  logic [4:0]          exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    m_ptr = 0;
    exp_q.delete();
  endtask

  function automatic logic [4:0] model_lookup(input plb_lookup_req_t r);
    logic hit;
    logic ok;
    logic [2:0] p;
    hit = 1'b0;
    p   = 3'b000;
    for (int k = 0; k < N; k++)
      if (m_valid[k] && m_sdid[k] == r.sdid && m_page[k] == r.spa[XLEN-1:12]) begin
        hit = 1'b1;
        p   = m_perms[k];
      end
    case (r.access)
      ACCESS_READ:  ok = p[0];
      ACCESS_WRITE: ok = p[1];
      ACCESS_EXEC:  ok = p[2];
      default:      ok = 1'b0;
    endcase
    return {hit, hit & ok, p};
  endfunction

  task automatic model_fill(input plb_entry_t e);
    int slot;
    slot = -1;
    for (int k = 0; k < N; k++)
      if (slot < 0 && m_valid[k] && m_sdid[k] == e.sdid && m_page[k] == e.spa[XLEN-1:12]) slot = k;
    for (int k = 0; k < N; k++)
      if (slot < 0 && !m_valid[k]) slot = k;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % N;
    end
    m_valid[slot] = 1'b1;
    m_sdid[slot]  = e.sdid;
    m_page[slot]  = e.spa[XLEN-1:12];
    m_perms[slot] = e.perms;
  endtask

  function automatic plb_lookup_req_t mk_req(input int sdid, input logic [63:0] spa,
                                             input access_type_e acc);
    plb_lookup_req_t r;
    r.sdid   = SDID_LEN'(sdid);
    r.spa    = spa;
    r.access = acc;
    return r;
  endfunction

  function automatic plb_entry_t mk_fill(input int sdid, input logic [63:0] spa,
                                         input mpt_permissions_e p);
    plb_entry_t e;
    e.sdid  = SDID_LEN'(sdid);
    e.spa   = spa;
    e.perms = p;
    return e;
  endfunction

  // One clock cycle: score the outputs of the previous edge, drive new inputs, advance the model.
  task automatic drive_cycle(input logic rv, input plb_lookup_req_t rq, input logic fv,
                             input plb_entry_t fe, input logic fl, input logic rr,
                             input logic fs, input logic [SDID_LEN-1:0] fsid);
    logic acc;
    logic drop;
    @(negedge clk);
    check("resp_valid", resp_valid, exp_q.size() != 0);
    if (resp_valid && exp_q.size() != 0)
      check("resp_payload", {resp_hit, resp_perm_ok, resp_perms}, exp_q[0]);
    req_valid     = rv;
    req           = rq;
    fill_valid    = fv;
    fill_entry    = fe;
    flush         = fl;
    resp_ready    = rr;
    flush_sdid    = fs;
    flush_sdid_id = fsid;
    #1;
    check("req_ready", req_ready, (exp_q.size() == 0) || rr);
    acc = rv && ((exp_q.size() == 0) || rr);
    if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(fl ? 5'b0 : model_lookup(rq));
    if (fl) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      m_ptr = 0;
    end else begin
      drop = 1'b0;
`ifdef MPT_PLB_SDID_FLUSH_EN
      drop = fs && (fe.sdid == fsid);
`endif
      if (fv && !drop) model_fill(fe);
`ifdef MPT_PLB_SDID_FLUSH_EN
      if (fs)
        for (int k = 0; k < N; k++)
          if (m_valid[k] && m_sdid[k] == fsid) m_valid[k] = 1'b0;
`endif
    end
  endtask

  task automatic idle();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_flush();
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic do_lookup(input int sdid, input logic [63:0] spa, input access_type_e acc);
    drive_cycle(1'b1, mk_req(sdid, spa, acc), 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_fill(input int sdid, input logic [63:0] spa, input mpt_permissions_e p);
    drive_cycle(1'b0, '0, 1'b1, mk_fill(sdid, spa, p), 1'b0, 1'b1, 1'b0, '0);
  endtask

  // Directed check of the response registered by the cycle just driven.
  task automatic dir_check(input string tag, input logic ehit, input logic eok,
                           input logic [2:0] ep);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, resp_valid, 1'b1);
    check(tag, {resp_hit, resp_perm_ok, resp_perms}, {ehit, eok, ep});
  endtask

  task automatic random_phase(input int cycles);
    plb_lookup_req_t rq;
    plb_entry_t      fe;
    logic            rv, fv, fl, rr, fs;
    logic [SDID_LEN-1:0] fsid;
    for (int c = 0; c < cycles; c++) begin
      rq.sdid   = ($urandom_range(0, 1) != 0) ? SDID_LEN'(3) : SDID_LEN'(5);
      rq.spa    = 64'h8000_0000 + (64'($urandom_range(0, 11)) << 12) + 64'($urandom_range(0, 4095));
      rq.access = access_type_e'($urandom_range(0, 3));
      fe.sdid   = ($urandom_range(0, 1) != 0) ? SDID_LEN'(3) : SDID_LEN'(5);
      fe.spa    = 64'h8000_0000 + (64'($urandom_range(0, 11)) << 12) + 64'($urandom_range(0, 4095));
      fe.perms  = mpt_permissions_e'($urandom_range(0, 7));
      rv   = ($urandom_range(0, 3) != 0);
      fv   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 63) == 0);
      rr   = ($urandom_range(0, 3) != 0);
      fs   = ($urandom_range(0, 31) == 0);
      fsid = ($urandom_range(0, 1) != 0) ? SDID_LEN'(3) : SDID_LEN'(5);
      drive_cycle(rv, rq, fv, fe, fl, rr, fs, fsid);
    end
  endtask

  localparam logic [63:0] PB = 64'h1000_0000;
  localparam logic [63:0] PA = 64'h2000_0000;

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req = '0; resp_ready = 1'b1;
    fill_valid = 1'b0; fill_entry = '0; flush_sdid = 1'b0; flush_sdid_id = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_hit", resp_hit, 1'b0);
    check("rst_perm_ok", resp_perm_ok, 1'b0);
    check("rst_perms", resp_perms, 3'b000);
    check("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, then a fill and partial-offset lookups.
    do_lookup(3, 64'h8000_1234, ACCESS_READ);  dir_check("t1_miss", 1'b0, 1'b0, 3'b000);
    do_fill(3, 64'h8000_1000, ALLOW_R);
    do_lookup(3, 64'h8000_1FFC, ACCESS_READ);  dir_check("t2_read", 1'b1, 1'b1, 3'b001);
    do_lookup(3, 64'h8000_1FFC, ACCESS_WRITE); dir_check("t2_write", 1'b1, 1'b0, 3'b001);
    do_lookup(5, 64'h8000_1000, ACCESS_READ);  dir_check("t2_other_sdid", 1'b0, 1'b0, 3'b000);

    // Replacement: 9 pages into 8 entries, then the pointer walks on.
    do_flush();
    for (int p = 1; p <= 9; p++) do_fill(3, PB + (64'(p) << 12), ALLOW_RW);
    do_lookup(3, PB + (64'd1 << 12), ACCESS_READ);  dir_check("t3_p1_evicted", 1'b0, 1'b0, 3'b000);
    do_lookup(3, PB + (64'd9 << 12), ACCESS_READ);  dir_check("t3_p9_hit", 1'b1, 1'b1, 3'b011);
    do_fill(3, PB + (64'd1 << 12), ALLOW_RW);
    do_lookup(3, PB + (64'd1 << 12), ACCESS_WRITE); dir_check("t3_p1_back", 1'b1, 1'b1, 3'b011);
    do_lookup(3, PB + (64'd2 << 12), ACCESS_READ);  dir_check("t3_p2_evicted", 1'b0, 1'b0, 3'b000);
    do_fill(3, PB + (64'd10 << 12), ALLOW_RW);
    do_lookup(3, PB + (64'd3 << 12), ACCESS_READ);  dir_check("t3_p3_evicted", 1'b0, 1'b0, 3'b000);
    do_lookup(3, PB + (64'd4 << 12), ACCESS_READ);  dir_check("t3_p4_kept", 1'b1, 1'b1, 3'b011);

    // Overwrite in place keeps the other entries.
    do_flush();
    do_fill(3, PA, ALLOW_R);
    for (int k = 1; k <= 7; k++) do_fill(3, PA + (64'(k) << 12), ALLOW_RX);
    do_fill(3, PA + 64'h10, ALLOW_RWX);
    do_lookup(3, PA, ACCESS_WRITE); dir_check("t4_a_rwx", 1'b1, 1'b1, 3'b111);
    for (int k = 1; k <= 7; k++) begin
      do_lookup(3, PA + (64'(k) << 12), ACCESS_READ);
      dir_check("t4_other", 1'b1, 1'b1, 3'b101);
    end

    // Backpressure: response held, no new accept until released.
    idle();
    drive_cycle(1'b1, mk_req(3, PA, ACCESS_READ), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int s = 0; s < 3; s++) begin
      drive_cycle(1'b1, mk_req(3, PA + (64'd2 << 12), ACCESS_READ), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      check("t5_stall_ready", req_ready, 1'b0);
      check("t5_stable", {resp_valid, resp_hit, resp_perm_ok, resp_perms}, 6'b1_1_1_111);
    end
    drive_cycle(1'b1, mk_req(3, PA + (64'd2 << 12), ACCESS_READ), 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    dir_check("t5_next", 1'b1, 1'b1, 3'b101);
    idle();
    idle();

    // Global flush with same-cycle fill and lookup.
    drive_cycle(1'b1, mk_req(3, PA, ACCESS_READ), 1'b1, mk_fill(3, 64'h3000_0000, ALLOW_RWX),
                1'b1, 1'b1, 1'b0, '0);
    dir_check("t6_flush_miss", 1'b0, 1'b0, 3'b000);
    do_lookup(3, 64'h3000_0000, ACCESS_READ); dir_check("t6_fill_dropped", 1'b0, 1'b0, 3'b000);
    do_lookup(3, PA, ACCESS_READ);            dir_check("t6_a_flushed", 1'b0, 1'b0, 3'b000);

`ifdef MPT_PLB_SDID_FLUSH_EN
    do_fill(3, PB, ALLOW_R);
    do_fill(5, PB, ALLOW_RW);
    do_fill(3, PB + 64'h1000, ALLOW_R);
    do_fill(5, PB + 64'h1000, ALLOW_RW);
    drive_cycle(1'b0, '0, 1'b1, mk_fill(5, PB + 64'h2000, ALLOW_X), 1'b0, 1'b1, 1'b1, SDID_LEN'(3));
    drive_cycle(1'b0, '0, 1'b1, mk_fill(3, PB + 64'h3000, ALLOW_X), 1'b0, 1'b1, 1'b1, SDID_LEN'(3));
    do_lookup(3, PB, ACCESS_READ);           dir_check("t6s_sdid3_miss", 1'b0, 1'b0, 3'b000);
    do_lookup(5, PB, ACCESS_WRITE);          dir_check("t6s_sdid5_hit", 1'b1, 1'b1, 3'b011);
    do_lookup(5, PB + 64'h1000, ACCESS_READ); dir_check("t6s_sdid5_hit2", 1'b1, 1'b1, 3'b011);
    do_lookup(5, PB + 64'h2000, ACCESS_EXEC); dir_check("t6s_fill_kept", 1'b1, 1'b1, 3'b100);
    do_lookup(3, PB + 64'h3000, ACCESS_EXEC); dir_check("t6s_fill_drop", 1'b0, 1'b0, 3'b000);
`endif

    random_phase(3000);

    // Reset in the middle of a stalled response.
    drive_cycle(1'b1, mk_req(3, PA, ACCESS_READ), 1'b1, mk_fill(3, PA, ALLOW_R),
                1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    resp_ready = 1'b0; flush_sdid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(3, PA, ACCESS_READ); dir_check("midrst_miss", 1'b0, 1'b0, 3'b000);
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
